// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin arbiter clients: client indexing,
// requester FSM states and the arbiter's one-hot grant encoding.
package rr_pkg;

    localparam int NUM_CLIENTS = 4;

    typedef logic [1:0] client_id_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PEND = 2'd1,
        S_LAST = 2'd2
    } state_t;

    localparam logic [NUM_CLIENTS-1:0] GRANT_C0 = 4'b0001;
    localparam logic [NUM_CLIENTS-1:0] GRANT_C1 = 4'b0010;
    localparam logic [NUM_CLIENTS-1:0] GRANT_C2 = 4'b0100;
    localparam logic [NUM_CLIENTS-1:0] GRANT_C3 = 4'b1000;

    // With one word left the request has to fall as soon as the grant arrives.
    function automatic state_t state_of(input int unsigned count);
        if (count == 0)
            return S_IDLE;
        else if (count == 1)
            return S_LAST;
        else
            return S_PEND;
    endfunction

endpackage

// File: rtl/rr_requester_if.sv
// Producer, arbiter and output-bus signals of one round-robin client.
// The master modport is the requester, the slave modport its environment.
interface rr_requester_if #(
    parameter int DATA_W = 8
) ();
    import rr_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              req;
    logic              grant;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    client_id_t        bus_id;

    modport master (
        input  in_valid, in_data, grant,
        output in_ready, req, bus_valid, bus_data, bus_id
    );

    modport slave (
        output in_valid, in_data, grant,
        input  in_ready, req, bus_valid, bus_data, bus_id
    );

endinterface

// File: rtl/rr_req_fifo.sv
// DEPTH-entry word buffer for the requester; pointers wrap naturally because
// DEPTH is a power of two. Callers never push when full or pop when empty.
module rr_req_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/rr_requester.sv
// Round-robin arbiter client: queues words, requests while any are pending and
// issues one word per granted cycle. RR_REQUESTER_STATS_EN adds grant counters.
module rr_requester
    import rr_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int CLIENT_ID = 0
) (
    input  logic           clk,
    input  logic           rst,
    rr_requester_if.master link
`ifdef RR_REQUESTER_STATS_EN
    ,
    output logic [15:0]    grant_cnt,
    output logic [7:0]     spurious_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] head;
    state_t            state_q;
    state_t            state_d;

    rr_req_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (link.in_data),
        .rd_data (head),
        .count   (count)
    );

    // A full FIFO refuses input even when the head is leaving this cycle.
    assign link.in_ready = (count < CNT_W'(DEPTH));
    assign push          = link.in_valid & link.in_ready;
    assign pop           = link.grant & (count != '0);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_of(32'(count_next));
        link.req = 1'b0;
        case (state_q)
            S_PEND:  link.req = 1'b1;
            S_LAST:  link.req = ~link.grant;
            default: link.req = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            link.bus_valid <= 1'b0;
            link.bus_data  <= '0;
            link.bus_id    <= '0;
        end else begin
            link.bus_valid <= pop;
            if (pop) begin
                link.bus_data <= head;
                link.bus_id   <= client_id_t'(CLIENT_ID);
            end
        end
    end

`ifdef RR_REQUESTER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt    <= '0;
            spurious_cnt <= '0;
        end else begin
            if (pop)
                grant_cnt <= grant_cnt + 16'd1;
            if (link.grant && (count == '0) && (spurious_cnt != 8'hFF))
                spurious_cnt <= spurious_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_requester.sv
// Directed bench for rr_requester: a queue model checked every cycle plus
// literal expectations per scenario. Honours RR_REQUESTER_STATS_EN.
module tb_rr_requester;
    import rr_pkg::*;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 4;
    localparam int CLIENT_ID = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rr_requester_if #(.DATA_W(DATA_W)) link ();

`ifdef RR_REQUESTER_STATS_EN
    logic [15:0] grant_cnt;
    logic [7:0]  spurious_cnt;
`endif

    rr_requester #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .CLIENT_ID (CLIENT_ID)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .link (link)
`ifdef RR_REQUESTER_STATS_EN
        ,
        .grant_cnt    (grant_cnt),
        .spurious_cnt (spurious_cnt)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit check_en  = 1'b0;

    logic [DATA_W-1:0] mq[$];
    logic              exp_bus_valid = 1'b0;
    logic [DATA_W-1:0] exp_bus_data  = '0;
    int                exp_grants    = 0;
    int                exp_spur      = 0;
    bit                m_pop;
    bit                m_push;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic apply_stimulus(input logic v, input logic [DATA_W-1:0] d, input logic g);
        link.in_valid = v;
        link.in_data  = d;
        link.grant    = g;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue model: a word leaves on each grant while anything is stored.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            exp_bus_valid = 1'b0;
            exp_bus_data  = '0;
            exp_grants    = 0;
            exp_spur      = 0;
        end else begin
            m_pop  = link.grant && (mq.size() > 0);
            m_push = link.in_valid && (mq.size() < DEPTH);
            if (link.grant && mq.size() == 0 && exp_spur < 255)
                exp_spur++;
            if (m_pop) begin
                exp_bus_data  = mq.pop_front();
                exp_bus_valid = 1'b1;
                exp_grants++;
            end else begin
                exp_bus_valid = 1'b0;
            end
            if (m_push)
                mq.push_back(link.in_data);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            int pending;
            pending = mq.size() - ((link.grant && mq.size() > 0) ? 1 : 0);
            check_output("model_in_ready", 32'(link.in_ready), 32'(mq.size() < DEPTH));
            check_output("model_req", 32'(link.req), 32'(pending != 0));
            check_output("model_bus_valid", 32'(link.bus_valid), 32'(exp_bus_valid));
            if (exp_bus_valid) begin
                check_output("model_bus_data", 32'(link.bus_data), 32'(exp_bus_data));
                check_output("model_bus_id", 32'(link.bus_id), CLIENT_ID);
            end
`ifdef RR_REQUESTER_STATS_EN
            check_output("model_grant_cnt", 32'(grant_cnt), 32'(exp_grants & 16'hFFFF));
            check_output("model_spurious_cnt", 32'(spurious_cnt), 32'(exp_spur));
`endif
        end
    end

    initial begin
        apply_stimulus(1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b1;
        check_en = 1'b1;

        $display("[TB] reset release");
        tick();
        check_output("rst_req", 32'(link.req), 0);
        check_output("rst_in_ready", 32'(link.in_ready), 1);
        check_output("rst_bus_valid", 32'(link.bus_valid), 0);
        check_output("rst_bus_data", 32'(link.bus_data), 0);
        check_output("rst_bus_id", 32'(link.bus_id), 0);

        $display("[TB] single word 0xA5");
        apply_stimulus(1'b1, 8'hA5, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b0);
        check_output("a5_req_up", 32'(link.req), 1);
        tick();
        apply_stimulus(1'b0, '0, 1'b1);
        #1;
        check_output("a5_req_drop", 32'(link.req), 0);
        tick();
        check_output("a5_bus_valid", 32'(link.bus_valid), 1);
        check_output("a5_bus_data", 32'(link.bus_data), 32'h A5);
        check_output("a5_bus_id", 32'(link.bus_id), CLIENT_ID);
        tick();
        check_output("a5_no_second", 32'(link.bus_valid), 0);
        apply_stimulus(1'b0, '0, 1'b0);
        tick();

        $display("[TB] fill to full, then drain on alternate grants");
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1'b1, 8'(i), 1'b0);
            tick();
        end
        check_output("full_in_ready", 32'(link.in_ready), 0);
        apply_stimulus(1'b1, 8'h05, 1'b0);
        tick();
        check_output("full_refused", 32'(link.in_ready), 0);
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1'b0, '0, 1'b1);
            tick();
            check_output("drain_valid", 32'(link.bus_valid), 1);
            check_output("drain_data", 32'(link.bus_data), i);
            apply_stimulus(1'b0, '0, 1'b0);
            tick();
            check_output("drain_gap", 32'(link.bus_valid), 0);
        end
        check_output("drain_req_low", 32'(link.req), 0);

        $display("[TB] push and pop together at count 2");
        apply_stimulus(1'b1, 8'h11, 1'b0);
        tick();
        apply_stimulus(1'b1, 8'h22, 1'b0);
        tick();
        apply_stimulus(1'b1, 8'h33, 1'b1);
        tick();
        check_output("pp_data0", 32'(link.bus_data), 32'h11);
        apply_stimulus(1'b0, '0, 1'b1);
        #1;
        check_output("pp_req_pend", 32'(link.req), 1);
        tick();
        check_output("pp_data1", 32'(link.bus_data), 32'h22);
        check_output("pp_req_last", 32'(link.req), 0);
        tick();
        check_output("pp_data2", 32'(link.bus_data), 32'h33);
        apply_stimulus(1'b0, '0, 1'b0);
        tick();

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 8'h61 + 8'(i), 1'b0);
            tick();
        end
        apply_stimulus(1'b0, '0, 1'b1);
        tick();
        apply_stimulus(1'b0, '0, 1'b0);
        rst = 1'b0;
        #1;
        check_output("mid_rst_req", 32'(link.req), 0);
        check_output("mid_rst_valid", 32'(link.bus_valid), 0);
        check_output("mid_rst_in_ready", 32'(link.in_ready), 1);
        tick();
        rst = 1'b1;
        apply_stimulus(1'b1, 8'h5A, 1'b0);
        tick();
        apply_stimulus(1'b0, '0, 1'b1);
        tick();
        check_output("post_rst_data", 32'(link.bus_data), 32'h5A);
        check_output("post_rst_valid", 32'(link.bus_valid), 1);
        apply_stimulus(1'b0, '0, 1'b0);
        tick();

        $display("[TB] spurious grant while empty");
        apply_stimulus(1'b0, '0, 1'b1);
        tick();
        apply_stimulus(1'b0, '0, 1'b0);
        check_output("spur_no_valid", 32'(link.bus_valid), 0);
        tick();
`ifdef RR_REQUESTER_STATS_EN
        check_output("spur_cnt", 32'(spurious_cnt), 1);
        check_output("spur_grant_cnt", 32'(grant_cnt), 1);
`endif
        tick();

        check_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
